// File: rtl/register_file_pkg.sv
// Shared types and constants for the sixteen-entry general-purpose register
// file that feeds the ALU operands and accepts the writeback result.
package register_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int SEL_WIDTH  = 4;
    localparam int NUM_REGS   = 1 << SEL_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [SEL_WIDTH-1:0]  reg_sel_t;

endpackage

// File: rtl/register_32.sv
// One register-file entry: a word-wide register that captures its input on a
// rising clock edge only while its load line is high, and clears to zero the
// moment reset is pulled low.
module register_32
    import register_file_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next value is the incoming word when loaded, otherwise the stored word
    // is recirculated so the entry holds.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end
    end

    // Storage element; the clear is asynchronous so it wins over any write
    // that happens to coincide with reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/register_file_16x32.sv
// Sixteen-entry register file with two independent combinational read ports
// and one clocked write port. R0 is an ordinary register. Reads of a register
// being written show the old contents until the capturing edge; there is no
// write-through bypass.
module register_file_16x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [DATA_WIDTH-1:0] port_a,
    output logic [DATA_WIDTH-1:0] port_b,
    input  logic [SEL_WIDTH-1:0]  a_select,
    input  logic [SEL_WIDTH-1:0]  b_select,
    input  logic [DATA_WIDTH-1:0] port_c,
    input  logic [SEL_WIDTH-1:0]  decoder_control,
    input  logic                  load_enable
);

    localparam int NumRegs = 1 << SEL_WIDTH;

    logic [NumRegs-1:0]    writeOneHot;
    logic [DATA_WIDTH-1:0] regValue [NumRegs];

    // Write decoder: turns the destination number into a one-hot load vector,
    // and leaves every line low when writes are disabled so nothing changes.
    always_comb begin
        writeOneHot = '0;
        if (load_enable) begin
            writeOneHot[decoder_control] = 1'b1;
        end
    end

    // The sixteen storage entries all share the write data; only the entry
    // whose decoder line is high captures it.
    for (genvar i = 0; i < NumRegs; i++) begin : g_regs
        register_32 #(
            .WIDTH(DATA_WIDTH)
        ) u_reg (
            .clk    (clk),
            .reset_n(reset_n),
            .load_i (writeOneHot[i]),
            .data_i (port_c),
            .data_o (regValue[i])
        );
    end

    // Read port A: plain multiplexer from the stored words, zero latency.
    always_comb begin
        port_a = regValue[a_select];
    end

    // Read port B: independent copy of the same multiplexer so both operands
    // can be fetched in one cycle, including from the same register.
    always_comb begin
        port_b = regValue[b_select];
    end

endmodule

// File: tb/tb_register_file_16x32.sv
// Directed self-checking bench for the sixteen-entry register file: fill and
// readback, overwrite timing, disabled writes, dual read of one register and
// an asynchronous reset pulse in the middle of operation.
module tb_register_file_16x32;

    logic        clk;
    logic        reset_n;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic [3:0]  a_select;
    logic [3:0]  b_select;
    logic [31:0] port_c;
    logic [3:0]  decoder_control;
    logic        load_enable;

    int assertCount;
    int failCount;

    logic [31:0] expRegs [16];

    register_file_16x32 #(
        .DATA_WIDTH(32),
        .SEL_WIDTH (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .port_a         (port_a),
        .port_b         (port_b),
        .a_select       (a_select),
        .b_select       (b_select),
        .port_c         (port_c),
        .decoder_control(decoder_control),
        .load_enable    (load_enable)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Writes one register across a single rising edge and updates the model.
    // Inputs change on the falling edge, well away from the capturing edge.
    task automatic applyStimulus(input logic [3:0] dest, input logic [31:0] data);
        @(negedge clk);
        decoder_control = dest;
        port_c          = data;
        load_enable     = 1'b1;
        @(posedge clk);
        #1;
        expRegs[dest] = data;
        load_enable   = 1'b0;
    endtask

    // Walks every register through both read ports and compares with the model.
    task automatic checkAllRegs(input string tag);
        for (int i = 0; i < 16; i++) begin
            a_select = 4'(i);
            b_select = 4'(15 - i);
            #1;
            checkOutput($sformatf("%s_a_R%0d", tag, i), port_a, expRegs[i]);
            checkOutput($sformatf("%s_b_R%0d", tag, 15 - i), port_b, expRegs[15 - i]);
        end
    endtask

    initial begin
        assertCount     = 0;
        failCount       = 0;
        reset_n         = 1'b0;
        load_enable     = 1'b0;
        decoder_control = 4'd0;
        port_c          = 32'd0;
        a_select        = 4'd0;
        b_select        = 4'd0;
        for (int i = 0; i < 16; i++) expRegs[i] = 32'd0;

        // Reset state: everything reads zero.
        #12;
        checkAllRegs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Fill R[i] = i, then read evens on A and odds on B.
        for (int i = 0; i < 16; i++) applyStimulus(4'(i), 32'(i));
        for (int i = 0; i < 8; i++) begin
            a_select = 4'(2 * i);
            b_select = 4'(2 * i + 1);
            #1;
            checkOutput($sformatf("fill_a_%0d", 2 * i), port_a, 32'(2 * i));
            checkOutput($sformatf("fill_b_%0d", 2 * i + 1), port_b, 32'(2 * i + 1));
        end

        // Overwrite R10 with 50: old value before the edge, new value after.
        @(negedge clk);
        a_select        = 4'd10;
        decoder_control = 4'd10;
        port_c          = 32'd50;
        load_enable     = 1'b1;
        #1;
        checkOutput("overwrite_before", port_a, 32'd10);
        @(posedge clk);
        #1;
        load_enable  = 1'b0;
        expRegs[10]  = 32'd50;
        checkOutput("overwrite_after", port_a, 32'd50);
        checkAllRegs("overwrite_all");

        // Disabled writes: several edges with a tempting address and data.
        @(negedge clk);
        load_enable     = 1'b0;
        decoder_control = 4'd3;
        port_c          = 32'hDEADBEEF;
        a_select        = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("disabled_R3", port_a, 32'd3);
        checkAllRegs("disabled_all");

        // Same register on both ports, then rewrite it.
        a_select = 4'd7;
        b_select = 4'd7;
        #1;
        checkOutput("dual_a_old", port_a, 32'd7);
        checkOutput("dual_b_old", port_b, 32'd7);
        applyStimulus(4'd7, 32'hFFFFFFFF);
        a_select = 4'd7;
        b_select = 4'd7;
        #1;
        checkOutput("dual_a_new", port_a, 32'hFFFFFFFF);
        checkOutput("dual_b_new", port_b, 32'hFFFFFFFF);

        // Asynchronous reset between edges, with a write held up across an edge.
        @(negedge clk);
        #2;
        reset_n         = 1'b0;
        decoder_control = 4'd5;
        port_c          = 32'hA5A5A5A5;
        load_enable     = 1'b1;
        for (int i = 0; i < 16; i++) expRegs[i] = 32'd0;
        checkAllRegs("async_reset");
        @(posedge clk);
        #1;
        a_select = 4'd5;
        #1;
        checkOutput("reset_beats_write", port_a, 32'd0);
        @(negedge clk);
        load_enable = 1'b0;
        reset_n     = 1'b1;

        // Normal operation resumes after release.
        applyStimulus(4'd15, 32'h12345678);
        a_select = 4'd15;
        b_select = 4'd14;
        #1;
        checkOutput("post_reset_R15", port_a, 32'h12345678);
        checkOutput("post_reset_R14", port_b, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/register_file_16x32.md
# register_file_16x32

Sixteen-entry, 32-bit general-purpose register file for the basic RISC datapath. It has two independent combinational read ports (A and B) and one synchronous write port (C). A 4-bit decoder selects the write destination. It sits between the instruction decoder (register selects) and the ALU and writeback path.

## Interface
- `DATA_WIDTH`, default 32: width of each register and of every data port.
- `SEL_WIDTH`, default 4: select width; the register count is 2^SEL_WIDTH = 16.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset_n`  input  1: reset, asynchronous and active-low.
- `port_a`  output  32: contents of the register addressed by `a_select`.
- `port_b`  output  32: contents of the register addressed by `b_select`.
- `a_select`  input  4: read address for port A.
- `b_select`  input  4: read address for port B.
- `port_c`  input  32: write data.
- `decoder_control`  input  4: write destination register number.
- `load_enable`  input  1: write enable, active high.

## Operation
- Sixteen registers, R0 to R15, each 32 bits. R0 is an ordinary writable register, not hardwired to zero.
- Write path:
  - `decoder_control` drives a 4-to-16 one-hot decoder, gated by `load_enable`.
  - On a rising `clk` with `load_enable`=1, `R[decoder_control]` <= `port_c`.
  - All other registers hold their values.
  - With `load_enable`=0, no register changes, whatever `decoder_control` and `port_c` are.
- Read path:
  - `port_a` = `R[a_select]` and `port_b` = `R[b_select]`, through purely combinational 16:1 multiplexers.
  - The two ports are fully independent. `a_select` == `b_select` is legal and both ports then show the same value.
- Reading the register being written in the same cycle returns the old value until the clock edge, then the new value. There is no write-through bypass.
- Every select value is valid, so there are no out-of-range cases.
- All registers are exactly 32 bits wide, so there is no truncation or extension.

## Timing
- Write latency is one clock edge: the value appears on a read port selected to that register immediately after the capturing rising edge.
- Read latency is zero cycles: combinational from `a_select`/`b_select` and register state.
- Reset:
  - `reset_n`=0 immediately clears all sixteen registers to 0, independent of `clk`.
  - `port_a` and `port_b` therefore read 0 for any select while reset is held.
  - Reset overrides a simultaneous write.
  - Deasserting reset mid-operation resumes normal writes from the next rising edge.
- Inputs must meet setup and hold around the rising edge. `port_c` and `decoder_control` may change freely between edges.

## Structure
- Shared package `register_file_pkg`:
  - Constants `DATA_WIDTH`=32, `SEL_WIDTH`=4 and `NUM_REGS`=16.
  - Typedef `word_t`, a 32-bit logic vector.
  - Typedef `reg_sel_t`, a 4-bit logic vector.
- Natural sub-module `register_32`: a 32-bit register with load enable and async active-low clear. It is instantiated 16 times.
- The top level contains:
  - the 4-to-16 write decoder, either inline or as a `decoder_4to16` helper;
  - the two 16:1 read multiplexers.

## Test plan
- Fill and readback:
  - Reset, then with `load_enable`=1 write `R[i]`=i for i=0..15, one register per clock.
  - Then `load_enable`=0, and step `a_select`=0,2,...,14 with `b_select`=1,3,...,15.
  - Required: `port_a`=`a_select` and `port_b`=`b_select` at every step.
- Overwrite: after the fill, write 50 to R10 with `a_select`=10.
  - Required: `port_a` reads 10 until the rising edge and 50 after it; all other registers are unchanged.
- Write disabled: `load_enable`=0, `decoder_control`=3, `port_c`=0xDEADBEEF, over several edges.
  - Required: R3 still reads 3.
- Same-register dual read: `a_select`=`b_select`=7 after the fill.
  - Required: both ports read 7. Then write R7=0xFFFFFFFF; both ports read 0xFFFFFFFF after the edge.
- Async reset mid-operation: after the fill, pulse `reset_n` low between clock edges.
  - Required: `port_a` and `port_b` read 0 immediately for all selects.
  - Required: after release, a write of 0x12345678 to R15 reads back correctly on the next edge.
